// File: rtl/game_pkg.sv
// Shared types and defaults for the game board datapath.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DUMP
  } state_t;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_SHIFT,
    OP_ROTATE
  } board_op_t;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_SW    = 9;
  localparam int unsigned SCORE_MAX     = (1 << DEFAULT_SW) - 1;

  function automatic logic [31:0] score_max(input int unsigned sw);
    return (32'd1 << sw) - 32'd1;
  endfunction

endpackage

// File: rtl/game_board_reg.sv
// WIDTH-bit game board: clear, serial shift-in, rotate-left and a tap read port.
module game_board_reg
  import game_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned PW    = $clog2(WIDTH)
) (
  input  logic          clka,
  input  logic          rst_n,
  input  board_op_t     op,
  input  logic          data_in,
  input  logic [PW-1:0] tap_idx,
  output logic          tap,
  output logic          msb
);

  logic [WIDTH-1:0] board;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      board <= '0;
    end else begin
      case (op)
        OP_CLEAR:  board <= '0;
        OP_SHIFT:  board <= {board[WIDTH-2:0], data_in};
        OP_ROTATE: board <= {board[WIDTH-2:0], board[WIDTH-1]};
        default:   board <= board;
      endcase
    end
  end

  assign tap = board[tap_idx];
  assign msb = board[WIDTH-1];

endmodule

// File: rtl/game_board_engine.sv
// Game board datapath: load, collision stepping, survival score and serial dump.
// Score counter is built only when GAME_SCORE_EN is defined.
module game_board_engine
  import game_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned PW    = $clog2(WIDTH),
  parameter int unsigned SW    = DEFAULT_SW
) (
  input  logic          clka,
  input  logic          rst_n,
  input  logic          load_data,
  input  logic          read_data,
  input  logic          writeout,
  input  logic          restart,
  input  logic          data_in,
  input  logic [PW-1:0] player_pos,
  output logic          data_out,
  output logic          out_valid,
  output logic          dump_done,
  output logic          busy,
  output logic          lose_sig,
  output logic [SW-1:0] score
);

  typedef enum logic [3:0] {
    ACT_NONE,
    ACT_RESTART,
    ACT_LOAD_START,
    ACT_LOAD_BIT,
    ACT_LOAD_LAST,
    ACT_LOAD_ABORT,
    ACT_DUMP_START,
    ACT_DUMP_BIT,
    ACT_DUMP_END,
    ACT_STEP_SAFE,
    ACT_STEP_LOSE
  } act_t;

  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0] CNT_LAST = (PW+1)'(WIDTH - 1);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(WIDTH);

  state_t      state;
  logic [PW:0] bit_cnt;
  logic        wo_q;
  logic        wo_rise;
  logic        tap;
  logic        msb;
  act_t        act;
  board_op_t   op;

  assign wo_rise = writeout & ~wo_q;

  // One decoded action per cycle drives both the board operation and the FSM,
  // so the two can never disagree about what happens this cycle.
  always_comb begin
    act = ACT_NONE;
    if (restart) begin
      act = ACT_RESTART;
    end else begin
      case (state)
        IDLE: begin
          if (load_data)                  act = ACT_LOAD_START;
          else if (wo_rise)               act = ACT_DUMP_START;
          else if (read_data && !lose_sig) act = tap ? ACT_STEP_LOSE : ACT_STEP_SAFE;
        end
        LOAD: begin
          if (!load_data)               act = ACT_LOAD_ABORT;
          else if (bit_cnt == CNT_LAST) act = ACT_LOAD_LAST;
          else                          act = ACT_LOAD_BIT;
        end
        DUMP:    act = (bit_cnt == CNT_FULL) ? ACT_DUMP_END : ACT_DUMP_BIT;
        default: act = ACT_NONE;
      endcase
    end
  end

  always_comb begin
    op = OP_HOLD;
    case (act)
      ACT_RESTART:                                 op = OP_CLEAR;
      ACT_LOAD_START, ACT_LOAD_BIT, ACT_LOAD_LAST: op = OP_SHIFT;
      ACT_DUMP_START, ACT_DUMP_BIT, ACT_STEP_SAFE: op = OP_ROTATE;
      default:                                     op = OP_HOLD;
    endcase
  end

  game_board_reg #(
    .WIDTH (WIDTH),
    .PW    (PW)
  ) u_board (
    .clka    (clka),
    .rst_n   (rst_n),
    .op      (op),
    .data_in (data_in),
    .tap_idx (player_pos),
    .tap     (tap),
    .msb     (msb)
  );

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      wo_q      <= 1'b0;
      lose_sig  <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= 1'b0;
      dump_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wo_q      <= writeout;
      dump_done <= 1'b0;
      case (act)
        ACT_RESTART: begin
          state     <= IDLE;
          bit_cnt   <= '0;
          lose_sig  <= 1'b0;
          out_valid <= 1'b0;
          data_out  <= 1'b0;
          busy      <= 1'b0;
        end
        ACT_LOAD_START: begin
          state   <= LOAD;
          bit_cnt <= CNT_ONE;
          busy    <= 1'b1;
        end
        ACT_LOAD_BIT: bit_cnt <= bit_cnt + 1'b1;
        ACT_LOAD_LAST: begin
          state   <= IDLE;
          bit_cnt <= bit_cnt + 1'b1;
          busy    <= 1'b0;
        end
        ACT_LOAD_ABORT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        ACT_DUMP_START: begin
          state     <= DUMP;
          bit_cnt   <= CNT_ONE;
          busy      <= 1'b1;
          out_valid <= 1'b1;
          data_out  <= msb;
        end
        ACT_DUMP_BIT: begin
          bit_cnt  <= bit_cnt + 1'b1;
          data_out <= msb;
        end
        ACT_DUMP_END: begin
          state     <= IDLE;
          bit_cnt   <= '0;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          data_out  <= 1'b0;
          dump_done <= 1'b1;
        end
        ACT_STEP_LOSE: lose_sig <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef GAME_SCORE_EN
  localparam logic [SW-1:0] SCORE_TOP = SW'(score_max(SW));

  logic [SW-1:0] score_q;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= '0;
    end else if (act == ACT_RESTART) begin
      score_q <= '0;
    end else if (act == ACT_STEP_SAFE && score_q != SCORE_TOP) begin
      score_q <= score_q + 1'b1;
    end
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_game_board_engine.sv
// Bench for game_board_engine: directed scenarios plus randomized traffic against a behavioural model.
module tb_game_board_engine;

  localparam int unsigned W   = 16;
  localparam int unsigned PWB = 4;
  localparam int unsigned SWB = 9;
  localparam int          SMAX = (1 << SWB) - 1;
`ifdef GAME_SCORE_EN
  localparam bit SCORE_ON = 1'b1;
`else
  localparam bit SCORE_ON = 1'b0;
`endif

  logic           clka = 1'b0;
  logic           rst_n = 1'b0;
  logic           load_data = 1'b0;
  logic           read_data = 1'b0;
  logic           writeout = 1'b0;
  logic           restart = 1'b0;
  logic           data_in = 1'b0;
  logic [PWB-1:0] player_pos = '0;
  logic           data_out, out_valid, dump_done, busy, lose_sig;
  logic [SWB-1:0] score;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clka = ~clka;

  game_board_engine #(
    .WIDTH (W),
    .PW    (PWB),
    .SW    (SWB)
  ) dut (
    .clka       (clka),
    .rst_n      (rst_n),
    .load_data  (load_data),
    .read_data  (read_data),
    .writeout   (writeout),
    .restart    (restart),
    .data_in    (data_in),
    .player_pos (player_pos),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .dump_done  (dump_done),
    .busy       (busy),
    .lose_sig   (lose_sig),
    .score      (score)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: board contents, a load counter and a queue of pending dump bits.
  logic [W-1:0] m_board;
  bit           m_wo, m_rise, m_loading, m_lose;
  int           m_loaded, m_score;
  bit           dq[$];
  bit           e_valid, e_data, e_done;

  always @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      m_board = '0; m_wo = 0; m_loading = 0; m_lose = 0; m_loaded = 0; m_score = 0;
      dq.delete(); e_valid = 0; e_data = 0; e_done = 0;
    end else begin
      m_rise = writeout && !m_wo;
      m_wo   = writeout;
      e_done = 0;
      if (restart) begin
        m_board = '0; m_loading = 0; m_lose = 0; m_score = 0;
        dq.delete(); e_valid = 0; e_data = 0;
      end else if (m_loading) begin
        if (!load_data) m_loading = 0;
        else begin
          m_board = {m_board[W-2:0], data_in};
          m_loaded++;
          if (m_loaded == W) m_loading = 0;
        end
      end else if (e_valid) begin
        if (dq.size() == 0) begin
          e_valid = 0; e_data = 0; e_done = 1;
        end else e_data = dq.pop_front();
      end else if (load_data) begin
        m_board   = {m_board[W-2:0], data_in};
        m_loaded  = 1;
        m_loading = 1;
      end else if (m_rise) begin
        for (int i = W - 1; i >= 0; i--) dq.push_back(m_board[i]);
        e_data  = dq.pop_front();
        e_valid = 1;
      end else if (read_data && !m_lose) begin
        if (m_board[player_pos]) m_lose = 1;
        else begin
          m_board = {m_board[W-2:0], m_board[W-1]};
          if (m_score < SMAX) m_score++;
        end
      end
    end
  end

  always @(negedge clka) begin
    chk("out_valid", out_valid, e_valid);
    chk("dump_done", dump_done, e_done);
    chk("busy", busy, m_loading || e_valid);
    chk("lose_sig", lose_sig, m_lose);
    chk("score", score, SCORE_ON ? m_score : 0);
    if (e_valid) chk("data_out", data_out, e_data);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clka);
  endtask

  task automatic load_word(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) begin
      load_data = 1'b1;
      data_in   = v[i];
      @(negedge clka);
    end
    load_data = 1'b0;
  endtask

  task automatic dump_capture(output logic [W-1:0] v, output int nv, output bit dn);
    v = '0; nv = 0; dn = 0;
    writeout = 1'b1;
    for (int c = 0; c < W + 6 && !dn; c++) begin
      @(negedge clka);
      writeout = 1'b0;
      if (out_valid) begin
        v = {v[W-2:0], data_out};
        nv++;
      end
      if (dump_done) dn = 1;
    end
  endtask

  logic [W-1:0] cap;
  int           nv, nvalid;
  bit           dn, seen_done;

  initial begin
    // Reset asserted from time zero; check outputs mid-cycle.
    #13;
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst lose", lose_sig, 0);
    chk("rst score", score, 0);
    chk("rst dump_done", dump_done, 0);
    chk("rst data_out", data_out, 0);
    @(negedge clka);
    rst_n = 1'b1;
    tick(2);
    dump_capture(cap, nv, dn);
    chk("zero dump bits", cap, 16'h0000);
    chk("zero dump count", nv, 16);
    chk("zero dump done", dn, 1);

    // Load then two identical dumps.
    tick(1);
    load_word(16'hA5F0);
    tick(1);
    dump_capture(cap, nv, dn);
    chk("dump1 bits", cap, 16'hA5F0);
    chk("dump1 count", nv, 16);
    chk("dump1 done", dn, 1);
    tick(2);
    dump_capture(cap, nv, dn);
    chk("dump2 bits", cap, 16'hA5F0);
    chk("dump2 count", nv, 16);

    // Collision at position 3 after three safe rotations.
    tick(2);
    load_word(16'h0001);
    player_pos = 4'd3;
    read_data  = 1'b1;
    tick(3);
    chk("coll score3", score, SCORE_ON ? 3 : 0);
    chk("coll lose before", lose_sig, 0);
    tick(1);
    chk("coll lose", lose_sig, 1);
    tick(2);
    read_data = 1'b0;
    chk("coll score held", score, SCORE_ON ? 3 : 0);
    chk("coll lose held", lose_sig, 1);

    // Restart on the fifth dump bit.
    tick(1);
    writeout = 1'b1;
    nvalid = 0;
    for (int c = 0; c < W && nvalid < 5; c++) begin
      @(negedge clka);
      writeout = 1'b0;
      if (out_valid) nvalid++;
    end
    chk("abort reached bit5", nvalid, 5);
    restart = 1'b1;
    @(negedge clka);
    restart = 1'b0;
    chk("abort valid", out_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort lose", lose_sig, 0);
    chk("abort score", score, 0);
    seen_done = 0;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clka);
      if (dump_done) seen_done = 1;
    end
    chk("abort no done", seen_done, 0);
    dump_capture(cap, nv, dn);
    chk("abort board cleared", cap, 16'h0000);

    // Saturation on an empty board.
    tick(1);
    player_pos = 4'd7;
    read_data  = 1'b1;
    tick(600);
    read_data = 1'b0;
    tick(1);
    chk("sat score", score, SCORE_ON ? 511 : 0);
    chk("sat lose", lose_sig, 0);

    // load_data and writeout rise together: load wins.
    data_in   = 1'b1;
    load_data = 1'b1;
    writeout  = 1'b1;
    @(negedge clka);
    load_data = 1'b0;
    writeout  = 1'b0;
    chk("simul busy", busy, 1);
    chk("simul valid", out_valid, 0);
    tick(1);
    chk("simul idle", busy, 0);

    // restart with load_data: board cleared, stays idle.
    tick(2);
    load_word(16'hA5F0);
    restart   = 1'b1;
    load_data = 1'b1;
    @(negedge clka);
    restart   = 1'b0;
    load_data = 1'b0;
    chk("rst+load busy", busy, 0);
    tick(1);
    dump_capture(cap, nv, dn);
    chk("rst+load board", cap, 16'h0000);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clka);
      restart    = ($urandom_range(0, 63) == 0);
      if (load_data) load_data = ($urandom_range(0, 15) != 0);
      else           load_data = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) writeout = ~writeout;
      read_data  = ($urandom_range(0, 2) == 0);
      data_in    = $urandom_range(0, 1);
      player_pos = PWB'($urandom_range(0, W - 1));
    end
    restart = 0; load_data = 0; writeout = 0; read_data = 0;
    tick(W + 4);

    // Asynchronous reset in the middle of a dump.
    load_word(16'hFFFF);
    tick(1);
    writeout = 1'b1;
    @(negedge clka);
    writeout = 1'b0;
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    chk("async valid", out_valid, 0);
    chk("async busy", busy, 0);
    chk("async data_out", data_out, 0);
    @(negedge clka);
    rst_n = 1'b1;
    tick(2);
    dump_capture(cap, nv, dn);
    chk("async board cleared", cap, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
